// File: rtl/nf_tpu_fp8_pkg.sv
// Shared FP8 definitions for the TPU datapath blocks: widths, constants and
// the dot-product sequencer state encoding.
package nf_tpu_fp8_pkg;

  localparam int unsigned FP8_W = 8;

  localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;
  // E4M3 has no infinities; S.1111.111 is the only NaN pattern.
  localparam logic [FP8_W-1:0] FP8_NAN  = 8'h7F;
  // Largest finite magnitude (448.0), used when a result saturates.
  localparam logic [FP8_W-2:0] FP8_MAXM = 7'h7E;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } seq_state_e;

endpackage

// File: rtl/fp8_e4m3_fma.sv
// Combinational FP8 E4M3 fused multiply-add: y = a*b + c with a single
// round-to-nearest-even step. Out-of-range results saturate to +/-448, and
// any NaN operand yields NaN.
module fp8_e4m3_fma
  import nf_tpu_fp8_pkg::*;
(
  input  logic [FP8_W-1:0] a,
  input  logic [FP8_W-1:0] b,
  input  logic [FP8_W-1:0] c,
  output logic [FP8_W-1:0] y
);

  // Operands are written as m * 2^(e-10), where subnormals take e=1 and no
  // hidden bit. The exact sum is then held as an integer in units of 2^-18,
  // the weight of the smallest possible product.
  logic [3:0]        ma, mb, mc;
  logic [3:0]        ea, eb, ec;
  logic [7:0]        pm;
  logic [39:0]       pmag, cmag, mag, rmask;
  logic signed [40:0] ps, cs, sum;
  logic              sgn, nan_in, rbit, sticky;
  logic [5:0]        lead, sh;
  logic [4:0]        q, q_r;
  logic [8:0]        code;

  // Decode, exact accumulate, normalise and round in one pass.
  always_comb begin
    ea = (a[6:3] == 4'd0) ? 4'd1 : a[6:3];
    eb = (b[6:3] == 4'd0) ? 4'd1 : b[6:3];
    ec = (c[6:3] == 4'd0) ? 4'd1 : c[6:3];
    ma = {a[6:3] != 4'd0, a[2:0]};
    mb = {b[6:3] != 4'd0, b[2:0]};
    mc = {c[6:3] != 4'd0, c[2:0]};

    pm   = {4'd0, ma} * {4'd0, mb};
    pmag = {32'd0, pm} << ({1'b0, ea} + {1'b0, eb} - 5'd2);
    cmag = {36'd0, mc} << ({1'b0, ec} + 5'd8);

    ps  = (a[7] ^ b[7]) ? -$signed({1'b0, pmag}) : $signed({1'b0, pmag});
    cs  = c[7] ? -$signed({1'b0, cmag}) : $signed({1'b0, cmag});
    sum = ps + cs;
    sgn = sum[40];
    mag = sgn ? 40'(-sum) : sum[39:0];

    lead = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (mag[i]) lead = 6'(i);
    end

    // Keep four significant bits; below the normal range the LSB is pinned
    // at 2^-9. With that choice the encoding is simply (sh-9)*8 + q, which
    // also absorbs the mantissa carry-out from rounding.
    sh     = (lead < 6'd12) ? 6'd9 : lead - 6'd3;
    q      = 5'(mag >> sh);
    rbit   = mag[sh - 6'd1];
    rmask  = (40'd1 << (sh - 6'd1)) - 40'd1;
    sticky = |(mag & rmask);
    q_r    = q + {4'd0, rbit & (sticky | q[0])};
    code   = ({3'd0, sh - 6'd9} << 3) + {4'd0, q_r};

    nan_in = (a[6:0] == 7'h7F) || (b[6:0] == 7'h7F) || (c[6:0] == 7'h7F);

    if (nan_in)
      y = FP8_NAN;
    else if (code > {2'd0, FP8_MAXM})
      y = {sgn, FP8_MAXM};
    else if (code == 9'd0)
      y = FP8_ZERO;
    else
      y = {sgn, code[6:0]};
  end

endmodule

// File: rtl/fp8_dot_sequencer.sv
// FP8 E4M3 dot-product sequencer: accepts len operand pairs over a
// valid/ready stream, accumulates through one FMA instance starting from
// init_c, and presents the result on a valid/ready output.
// Optional feature: define FP8_DOT_RELU_EN to clamp negative results to zero
// on out_data (the accumulator itself is left untouched).
module fp8_dot_sequencer
  import nf_tpu_fp8_pkg::*;
#(
  parameter int unsigned LEN_W   = 8,
  parameter bit          CNT_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [FP8_W-1:0] init_c,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP8_W-1:0] in_a,
  input  logic [FP8_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP8_W-1:0] out_data,
  output logic [LEN_W-1:0] beat_cnt
);

  seq_state_e       state;
  logic [FP8_W-1:0] acc;
  logic [FP8_W-1:0] fma_y;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] beat_cnt_r;

  fp8_e4m3_fma u_fma (
    .a (in_a),
    .b (in_b),
    .c (acc),
    .y (fma_y)
  );

  // out_data is registered, so the output view is applied to whatever value
  // is about to land in acc on the transition into DONE.
  function automatic logic [FP8_W-1:0] out_view(input logic [FP8_W-1:0] x);
`ifdef FP8_DOT_RELU_EN
    return x[FP8_W-1] ? FP8_ZERO : x;
`else
    return x;
`endif
  endfunction

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= FP8_ZERO;
      remaining  <= '0;
      beat_cnt_r <= '0;
      busy       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= FP8_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= len;
            acc        <= init_c;
            beat_cnt_r <= '0;
            busy       <= 1'b1;
            if (len != '0) begin
              state    <= ACCUM;
              in_ready <= 1'b1;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= out_view(init_c);
            end
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            acc        <= fma_y;
            remaining  <= remaining - 1'b1;
            beat_cnt_r <= beat_cnt_r + 1'b1;
            if (remaining == LEN_W'(1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= out_view(fma_y);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP8_ZERO;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= FP8_ZERO;
        end
      endcase
    end
  end

  generate
    if (CNT_OUT) begin : g_cnt
      assign beat_cnt = beat_cnt_r;
    end else begin : g_no_cnt
      assign beat_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Self-checking bench for fp8_dot_sequencer. Expected results come from a
// real-valued FP8 reference (exact product+sum, nearest-even search over all
// codes) or from hand-derived constants, queued when a run is launched and
// compared when the DUT hands out the result.
module tb_fp8_dot_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic [7:0] init_c;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] beat_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  va[16];
  logic [7:0]  vb[16];

  always #5 clk = ~clk;

  fp8_dot_sequencer #(.LEN_W(8), .CNT_OUT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .init_c    (init_c),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .beat_cnt  (beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp8_val(input logic [7:0] x);
    int  e = int'(x[6:3]);
    int  m = int'(x[2:0]);
    real v = (e == 0) ? m * pow2(-9) : (8 + m) * pow2(e - 10);
    return x[7] ? -v : v;
  endfunction

  function automatic logic [7:0] real_to_fp8(input real v);
    real        mag = (v < 0.0) ? -v : v;
    real        bd  = mag;
    real        d;
    logic [7:0] code;
    int         best = 0;
    for (int k = 1; k <= 126; k++) begin
      code = 8'(k);
      d = mag - fp8_val(code);
      if (d < 0.0) d = -d;
      if (d < bd || (d == bd && (k % 2) == 0)) begin
        bd   = d;
        best = k;
      end
    end
    if (best == 0) return 8'h00;
    return {v < 0.0, 7'(best)};
  endfunction

  function automatic logic [7:0] fma_model(input logic [7:0] a, b, c);
    return real_to_fp8(fp8_val(a) * fp8_val(b) + fp8_val(c));
  endfunction

  function automatic logic [7:0] relu_model(input logic [7:0] x);
`ifdef FP8_DOT_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [7:0] rand_fp8();
    logic [7:0] x = 8'($urandom_range(0, 255));
    if (x[6:0] == 7'h7F) x[6:0] = 7'h7E;
    return x;
  endfunction

  // Result scoreboard and idle-output check, sampled on the falling edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[15:8]);
          check("beat_cnt", beat_cnt, e[7:0]);
        end
      end
      if (!out_valid) check("out_data_zero_when_invalid", out_data, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  // Callers arrive just after a rising edge with the DUT idle.
  task automatic launch(input logic [7:0] n, input logic [7:0] c);
    start  = 1'b1;
    len    = n;
    init_c = c;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int unsigned gap);
    int unsigned k = 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 200);
    check("run_complete", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_model(input int unsigned n, input logic [7:0] c, input int unsigned gapmax);
    logic [7:0] acc = c;
    for (int unsigned i = 0; i < n; i++) acc = fma_model(va[i], vb[i], acc);
    exp_q.push_back({relu_model(acc), 8'(n)});
    launch(8'(n), c);
    for (int unsigned i = 0; i < n; i++) feed(va[i], vb[i], $urandom_range(0, gapmax));
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; init_c = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0 + 1*1 + 1*1 + 1*1 = 3.0
    exp_q.push_back({8'h44, 8'd3});
    launch(8'd3, 8'h00);
    repeat (3) feed(8'h38, 8'h38, 0);
    check("acc3_valid_after_last_beat", out_valid, 1);
    check("acc3_data_after_last_beat", out_data, 8'h44);
    wait_idle();

    // Zero length: result is init_c the cycle after start
    exp_q.push_back({8'h40, 8'd0});
    launch(8'd0, 8'h40);
    check("len0_in_ready", in_ready, 0);
    check("len0_out_valid", out_valid, 1);
    wait_idle();

    // Backpressure on both sides: 1 + 1*1 = 2, then 2 + 2*1 = 4.0
    exp_q.push_back({8'h48, 8'd2});
    out_ready = 1'b0;
    launch(8'd2, 8'h38);
    feed(8'h38, 8'h38, 0);
    repeat (2) begin
      @(negedge clk);
      check("stall_beat_cnt", beat_cnt, 1);
      check("stall_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    feed(8'h40, 8'h38, 0);
    repeat (5) begin
      @(negedge clk);
      check("hold_out_data", out_data, 8'h48);
      check("hold_busy", busy, 1);
      check("hold_out_valid", out_valid, 1);
    end
    // start in the handshake cycle must not launch a new run
    out_ready = 1'b1;
    start = 1'b1; len = 8'd5; init_c = 8'h38;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_on_handshake_ignored", busy, 0);
    @(posedge clk); #1;

    // ReLU view: -2 + 1*1 = -1.0
`ifdef FP8_DOT_RELU_EN
    exp_q.push_back({8'h00, 8'd1});
`else
    exp_q.push_back({8'hB8, 8'd1});
`endif
    launch(8'd1, 8'hC0);
    feed(8'h38, 8'h38, 0);
    wait_idle();

    // Reset in the middle of a run, then a clean run
    launch(8'd4, 8'h00);
    feed(8'h38, 8'h38, 0);
    feed(8'h38, 8'h38, 0);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_beat_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({8'h38, 8'd1});
    launch(8'd1, 8'h00);
    feed(8'h38, 8'h38, 0);
    wait_idle();

    // start during ACCUM is ignored: 0 + 2*1 + 1*1 = 3.0 after 2 beats
    exp_q.push_back({8'h44, 8'd2});
    launch(8'd2, 8'h00);
    start = 1'b1; len = 8'd7; init_c = 8'h50;
    @(posedge clk); #1;
    start = 1'b0;
    feed(8'h40, 8'h38, 0);
    feed(8'h38, 8'h38, 1);
    wait_idle();

    // Random runs against the reference model
    for (int r = 0; r < 8; r++) begin
      int unsigned n = $urandom_range(1, 6);
      logic [7:0]  c = rand_fp8();
      for (int unsigned i = 0; i < n; i++) begin
        va[i] = rand_fp8();
        vb[i] = rand_fp8();
      end
      run_model(n, c, 2);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp8_dot_sequencer.md
FP8_DOT_SEQUENCER -- requirements
Module: fp8_dot_sequencer

Interface
REQ-001 Parameter LEN_W, default 8, width of the vector-length field.
REQ-002 Parameter CNT_OUT, default 1, when 1 the block drives beat_cnt; when 0 beat_cnt is tied to 0.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
REQ-004 The block SHALL expose these ports:
- start  in  1  launch a dot product (sampled in IDLE only)
- len  in  LEN_W  number of (a,b) pairs, captured on start
- init_c  in  8  initial FP8 accumulator, captured on start
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid&in_ready
- in_a  in  8  FP8 E4M3 multiplicand
- in_b  in  8  FP8 E4M3 multiplier
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready
- out_data  out  8  FP8 E4M3 result
- beat_cnt  out  LEN_W  pairs accepted in the current run

Function
REQ-005 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-006 In IDLE, start=1 SHALL capture len into the remaining-count register, init_c into acc, and clear beat_cnt.
- Next state is ACCUM if len!=0.
- Next state is DONE if len==0.
REQ-007 in_ready SHALL be 1 only in ACCUM; in_valid SHALL be ignored in IDLE and DONE.
REQ-008 Each accepted beat SHALL register acc <= fp8_e4m3_fma(in_a, in_b, acc), decrement remaining, and increment beat_cnt.
- One beat per cycle maximum.
- The FMA path is combinational; latency is 1 cycle per beat.
REQ-009 When the beat that makes remaining reach 0 is accepted, next state SHALL be DONE.
REQ-010 In DONE, out_valid SHALL be 1 and out_data SHALL be driven from acc, held stable until out_ready.
REQ-011 out_valid&out_ready SHALL return the FSM to IDLE; start asserted in that same cycle SHALL be ignored.
REQ-012 start asserted in ACCUM or DONE SHALL be ignored, and len/init_c SHALL NOT be re-sampled.
REQ-013 in_valid=0 in ACCUM SHALL stall with acc, remaining and beat_cnt unchanged; there is no timeout.
REQ-014 out_data SHALL be 0x00 whenever out_valid=0.

Reset
REQ-015 rst=1 SHALL immediately force the following, regardless of state (including mid-run):
- state=IDLE, acc=0x00, remaining=0, beat_cnt=0
- busy=0, in_ready=0, out_valid=0, out_data=0x00
REQ-016 The first start after rst deassertion SHALL behave as a fresh run with no residue from the aborted run.

Configuration
REQ-017 With FP8_DOT_RELU_EN defined, out_data SHALL be 0x00 when acc[7]=1, and acc otherwise; acc itself is unaffected.
REQ-018 Without FP8_DOT_RELU_EN, out_data SHALL equal acc unmodified, and no ReLU logic SHALL be present.

Structure
REQ-019 Shared package nf_tpu_fp8_pkg SHALL hold:
- FP8 width constant (8)
- FP8_ZERO (0x00)
- the sequencer state enum
REQ-020 The arithmetic SHALL be a single instance of the existing fp8_e4m3_fma sub-module; the block SHALL NOT contain its own adder or multiplier.

Verification
REQ-021 Accumulation: start, len=3, init_c=0x00, three pairs (0x38,0x38) back-to-back -> out_valid 1 cycle after the 3rd beat, out_data=0x44, beat_cnt=3.
REQ-022 Zero length: start, len=0, init_c=0x40 -> in_ready never 1, out_valid next cycle, out_data=0x40.
REQ-023 Backpressure:
- len=2, in_valid toggled 1,0,0,1 -> exactly 2 beats accepted and acc unchanged on idle cycles.
- out_ready held 0 for 5 cycles -> out_data stable, busy=1 throughout.
REQ-024 ReLU: len=1, init_c=0xC0, pair (0x38,0x38) -> out_data=0x00 with FP8_DOT_RELU_EN, 0xB8 without.
REQ-025 Reset mid-run: len=4, rst asserted after 2 beats -> outputs zero in the same cycle; a new run (len=1, init 0x00, pair 0x38,0x38) then yields 0x38.
REQ-026 Ignored start: start pulsed during ACCUM with len=7 -> the run still completes after the original len beats.
